// File: rtl/pio_test_sequencer.sv
// PIO test sequencer: issues BAR write/read TLPs per iteration and scores the completions.
// Latency: tx_start asserts the cycle after WRITE/READ; one iteration per DONE/ERROR.
// Backpressure: each TLP waits on tx_done; reads wait on rx_success/rx_fail or a CPL_TIMEOUT-cycle timer.
module pio_test_sequencer #(
  parameter int          TCQ         = 1,
  parameter logic [63:0] BAR_BASE    = 64'h0000_0000_1000_0000,
  parameter int          BAR_SIZE_DW = 1024,
  parameter int          ADDR64      = 0,
  parameter int          LEN_DW      = 1,
  parameter int          MODE        = 0,
  parameter int          NUM_ITER    = 4096,
  parameter int          CPL_TIMEOUT = 1024,
  parameter logic [31:0] RD_EXPECT   = 32'h1234_5678
) (
  input  logic         user_clk,
  input  logic         reset,
  input  logic         user_lnk_up,
  output logic         start_config,
  input  logic         finished_config,
  input  logic         failed_config,
  output logic [2:0]   tx_type,
  output logic [7:0]   tx_tag,
  output logic [63:0]  tx_addr,
  output logic [127:0] tx_data,
  output logic [10:0]  tx_length,
  output logic         tx_start,
  input  logic         tx_done,
  output logic         rx_type,
  output logic [7:0]   rx_tag,
  output logic [31:0]  rx_data,
  input  logic         rx_success,
  input  logic         rx_fail,
  input  logic         restart,
  output logic         test_done,
  output logic [15:0]  pass_count,
  output logic [15:0]  err_count,
  output logic [15:0]  timeout_count
);

  typedef enum logic [3:0] {
    WAIT_CFG, WRITE, WRITE_WAIT, READ, READ_WAIT, CPL_WAIT, DONE, ERROR, TESTDONE
  } state_t;

  // TCQ only ever modelled a clock-to-out delay; it folds to zero here.
  localparam int          LEN      = LEN_DW + (TCQ * 0);
  localparam logic [31:0] LEN32    = 32'(LEN);
  localparam logic [31:0] BAR32    = 32'(BAR_SIZE_DW);
  localparam logic [31:0] CPL_LAST = 32'(CPL_TIMEOUT - 1);
  localparam logic [16:0] ITER_END = 17'(NUM_ITER);
  localparam logic [2:0]  WR_TYPE  = (ADDR64 != 0) ? 3'b011 : 3'b001;
  localparam logic [2:0]  RD_TYPE  = (ADDR64 != 0) ? 3'b010 : 3'b000;
  localparam state_t      FIRST_ST = (MODE == 2) ? READ : WRITE;

  state_t        state, state_nxt;
  logic          lnk_q1, lnk_q2;
  logic [15:0]   iter;
  logic [31:0]   offset, offset_inc, offset_nxt;
  logic [31:0]   cpl_cnt;
  logic [127:0]  pattern;
  logic          last_iter, cpl_timeout;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rx_tag = tx_tag;

  // Payload pattern, iteration bookkeeping and completion-timeout detect.
  always_comb begin
    pattern = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < LEN) pattern[32*k +: 32] = {iter, 8'hA5, 6'b0, 2'(k)};
    end
    offset_inc  = offset + LEN32;
    // Wrap before the next TLP would run past the end of the aperture.
    offset_nxt  = (offset_inc + LEN32 > BAR32) ? '0 : offset_inc;
    last_iter   = (17'(iter) + 17'd1) == ITER_END;
    cpl_timeout = (state == CPL_WAIT) && !rx_fail && !rx_success && (cpl_cnt == CPL_LAST);
  end

  // State register.
  always_ff @(posedge user_clk) begin
    if (reset) state <= WAIT_CFG;
    else       state <= state_nxt;
  end

  // Next-state logic; a dropped link overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_CFG:   if (failed_config) state_nxt = ERROR;
                  else if (finished_config) state_nxt = FIRST_ST;
      WRITE:      state_nxt = WRITE_WAIT;
      WRITE_WAIT: if (tx_done) state_nxt = (MODE == 0) ? READ : DONE;
      READ:       state_nxt = READ_WAIT;
      READ_WAIT:  if (tx_done) state_nxt = CPL_WAIT;
      CPL_WAIT:   if (rx_fail) state_nxt = ERROR;
                  else if (rx_success) state_nxt = DONE;
                  else if (cpl_timeout) state_nxt = ERROR;
      DONE, ERROR: state_nxt = last_iter ? TESTDONE : FIRST_ST;
      TESTDONE:   if (restart) state_nxt = FIRST_ST;
      default:    state_nxt = WAIT_CFG;
    endcase
    if (!user_lnk_up) state_nxt = WAIT_CFG;
  end

  // Link edge detect, TLP field capture, iteration/offset tracking and status counters.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      lnk_q1        <= 1'b0;
      lnk_q2        <= 1'b0;
      start_config  <= 1'b0;
      tx_type       <= '0;
      tx_tag        <= '0;
      tx_addr       <= '0;
      tx_data       <= '0;
      tx_length     <= '0;
      tx_start      <= 1'b0;
      rx_type       <= 1'b0;
      rx_data       <= '0;
      test_done     <= 1'b0;
      pass_count    <= '0;
      err_count     <= '0;
      timeout_count <= '0;
      iter          <= '0;
      offset        <= '0;
      cpl_cnt       <= '0;
    end else begin
      lnk_q1       <= user_lnk_up;
      lnk_q2       <= lnk_q1;
      start_config <= lnk_q1 & ~lnk_q2;
      tx_start     <= 1'b0;
      cpl_cnt      <= (state == CPL_WAIT) ? cpl_cnt + 32'd1 : '0;
      test_done    <= (state_nxt == TESTDONE);
      if (!user_lnk_up) begin
        // tx_tag deliberately survives a link drop so tags never repeat early.
        iter          <= '0;
        offset        <= '0;
        pass_count    <= '0;
        err_count     <= '0;
        timeout_count <= '0;
      end else begin
        case (state)
          WRITE, READ: begin
            tx_start  <= 1'b1;
            tx_tag    <= tx_tag + 8'd1;
            tx_type   <= (state == WRITE) ? WR_TYPE : RD_TYPE;
            tx_addr   <= BAR_BASE + 64'({offset, 2'b00});
            tx_data   <= pattern;
            tx_length <= 11'(LEN);
            rx_type   <= (state == READ);
            rx_data   <= (MODE == 2) ? RD_EXPECT : pattern[31:0];
          end
          DONE, ERROR: begin
            if (state == DONE) pass_count <= sat_inc(pass_count);
            else               err_count  <= sat_inc(err_count);
            iter   <= iter + 16'd1;
            offset <= offset_nxt;
          end
          TESTDONE: begin
            if (restart) begin
              iter          <= '0;
              offset        <= '0;
              pass_count    <= '0;
              err_count     <= '0;
              timeout_count <= '0;
            end
          end
          default: ;
        endcase
        if (cpl_timeout) timeout_count <= sat_inc(timeout_count);
      end
    end
  end

endmodule

// File: tb/tb_pio_test_sequencer.sv
// Bench for pio_test_sequencer: MODE 0, LEN_DW 3, BAR_SIZE_DW 8, NUM_ITER 4, CPL_TIMEOUT 16.
// Expected TLPs are queued per iteration and popped as the DUT raises tx_start.
// Responder returns tx_done 3 cycles after tx_start and a chosen completion outcome.
module tb_pio_test_sequencer;

  logic         user_clk = 1'b0;
  logic         reset, user_lnk_up, finished_config, failed_config;
  logic         tx_done, rx_success, rx_fail, restart;
  logic         start_config, tx_start, rx_type, test_done;
  logic [2:0]   tx_type;
  logic [7:0]   tx_tag, rx_tag;
  logic [63:0]  tx_addr;
  logic [127:0] tx_data;
  logic [10:0]  tx_length;
  logic [31:0]  rx_data;
  logic [15:0]  pass_count, err_count, timeout_count;

  always #5 user_clk = ~user_clk;

  pio_test_sequencer #(
    .TCQ(1), .BAR_BASE(64'h0000_0000_1000_0000), .BAR_SIZE_DW(8), .ADDR64(0),
    .LEN_DW(3), .MODE(0), .NUM_ITER(4), .CPL_TIMEOUT(16), .RD_EXPECT(32'h1234_5678)
  ) dut (
    .user_clk(user_clk), .reset(reset), .user_lnk_up(user_lnk_up),
    .start_config(start_config), .finished_config(finished_config), .failed_config(failed_config),
    .tx_type(tx_type), .tx_tag(tx_tag), .tx_addr(tx_addr), .tx_data(tx_data),
    .tx_length(tx_length), .tx_start(tx_start), .tx_done(tx_done),
    .rx_type(rx_type), .rx_tag(rx_tag), .rx_data(rx_data),
    .rx_success(rx_success), .rx_fail(rx_fail),
    .restart(restart), .test_done(test_done),
    .pass_count(pass_count), .err_count(err_count), .timeout_count(timeout_count)
  );

  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   tag;
    logic [63:0]  addr;
    logic [127:0] data;
    logic [10:0]  len;
    logic         rxt;
    logic [7:0]   rxtag;
    logic [31:0]  rxd;
  } tlp_t;

  tlp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tlp_total = 0;
  logic [7:0] m_tag = 8'h00;

  function automatic logic [127:0] pat(input int it);
    logic [127:0] p;
    logic [15:0]  i16;
    i16 = 16'(it);
    p = '0;
    p[31:0]  = {i16, 8'hA5, 8'h00};
    p[63:32] = {i16, 8'hA5, 8'h01};
    p[95:64] = {i16, 8'hA5, 8'h02};
    return p;
  endfunction

  // Queue the write then read expected for one iteration; odd iterations sit at DW offset 3.
  task automatic push_iter(input int it);
    tlp_t t;
    t.addr = 64'h0000_0000_1000_0000 + ((it % 2 == 1) ? 64'h0C : 64'h00);
    t.data = pat(it);
    t.len  = 11'd3;
    t.rxd  = t.data[31:0];
    m_tag = m_tag + 8'd1;
    t.typ = 3'b001; t.tag = m_tag; t.rxtag = m_tag; t.rxt = 1'b0;
    exp_q.push_back(t);
    m_tag = m_tag + 8'd1;
    t.typ = 3'b000; t.tag = m_tag; t.rxtag = m_tag; t.rxt = 1'b1;
    exp_q.push_back(t);
  endtask

  // Wait for one TLP, score it against the queue, optionally answer with tx_done.
  task automatic serve_tlp(input bit give_done);
    tlp_t o, e;
    int c = 0;
    while (tx_start !== 1'b1 && c < 40) begin
      @(negedge user_clk);
      c++;
    end
    n_cmp++;
    if (tx_start !== 1'b1) begin
      n_bad++;
      $display("FAIL tlp_wait: tx_start=%b after %0d cycles, required 1", tx_start, c);
      return;
    end
    o = {tx_type, tx_tag, tx_addr, tx_data, tx_length, rx_type, rx_tag, rx_data};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL tlp_extra: got %h, required no TLP", o);
    end else begin
      e = exp_q.pop_front();
      if (o !== e) begin
        n_bad++;
        $display("FAIL tlp tag %h: got %h required %h", e.tag, o, e);
      end
    end
    tlp_total++;
    if (give_done) begin
      repeat (3) @(negedge user_clk);
      tx_done = 1'b1;
      @(negedge user_clk);
      tx_done = 1'b0;
    end
  endtask

  // resp: 0 success, 1 fail, 2 both in one cycle, 3 silent.
  task automatic serve_iter(input int resp);
    serve_tlp(1'b1);
    serve_tlp(1'b1);
    if (resp != 3) begin
      repeat (2) @(negedge user_clk);
      rx_success = (resp == 0 || resp == 2);
      rx_fail    = (resp == 1 || resp == 2);
      @(negedge user_clk);
      rx_success = 1'b0;
      rx_fail    = 1'b0;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge user_clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; user_lnk_up = 1'b0; finished_config = 1'b0; failed_config = 1'b0;
    tx_done = 1'b0; rx_success = 1'b0; rx_fail = 1'b0; restart = 1'b0;
    repeat (3) @(negedge user_clk);
    reset = 1'b0;
    @(negedge user_clk);
    n_cmp++;
    if ({start_config, tx_start, test_done, rx_type} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b required 0000", {start_config, tx_start, test_done, rx_type});
    end
    n_cmp++;
    if (tx_tag !== 8'h00 || rx_tag !== 8'h00) begin
      n_bad++; $display("FAIL reset_tag: got %h/%h required 00/00", tx_tag, rx_tag);
    end
    n_cmp++;
    if (tx_addr !== 64'h0 || tx_data !== 128'h0 || tx_length !== 11'h0 || tx_type !== 3'h0 || rx_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_fields: got addr %h data %h len %h", tx_addr, tx_data, tx_length);
    end
    n_cmp++;
    if ({pass_count, err_count, timeout_count} !== 48'h0) begin
      n_bad++; $display("FAIL reset_counts: got %h/%h/%h required 0/0/0", pass_count, err_count, timeout_count);
    end
  endtask

  task automatic test_link_up();
    int highs = 0;
    user_lnk_up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge user_clk);
      if (start_config === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != 1) begin
      n_bad++; $display("FAIL start_config_pulse: high %0d cycles, required 1", highs);
    end
    finished_config = 1'b1;
    @(negedge user_clk);
    finished_config = 1'b0;
  endtask

  task automatic test_basic_run();
    int starts = 0;
    for (int it = 0; it < 4; it++) begin
      push_iter(it);
      serve_iter(0);
    end
    @(negedge user_clk);
    n_cmp++;
    if (pass_count !== 16'd4 || err_count !== 16'd0 || timeout_count !== 16'd0) begin
      n_bad++; $display("FAIL basic_counts: got %0d/%0d/%0d required 4/0/0", pass_count, err_count, timeout_count);
    end
    n_cmp++;
    if (test_done !== 1'b1) begin
      n_bad++; $display("FAIL basic_test_done: got %b required 1", test_done);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge user_clk);
      if (tx_start === 1'b1) starts++;
    end
    n_cmp++;
    if (starts != 0 || test_done !== 1'b1) begin
      n_bad++; $display("FAIL testdone_hold: %0d tx_start, test_done %b, required 0 and 1", starts, test_done);
    end
  endtask

  task automatic test_errors();
    pulse_restart();
    n_cmp++;
    if (pass_count !== 16'd0 || test_done !== 1'b0) begin
      n_bad++; $display("FAIL restart_clear: pass %0d test_done %b, required 0/0", pass_count, test_done);
    end
    // Fail and success in the same cycle: fail wins.
    push_iter(0);
    serve_iter(2);
    @(negedge user_clk);
    n_cmp++;
    if (err_count !== 16'd1 || pass_count !== 16'd0) begin
      n_bad++; $display("FAIL both_resp: err %0d pass %0d, required 1/0", err_count, pass_count);
    end
    // Mid-run restart must be ignored.
    pulse_restart();
    // Silent completer: ERROR exactly 16 cycles after CPL_WAIT entry.
    push_iter(1);
    serve_tlp(1'b1);
    serve_tlp(1'b1);
    repeat (15) @(negedge user_clk);
    n_cmp++;
    if (timeout_count !== 16'd0) begin
      n_bad++; $display("FAIL timeout_early: got %0d required 0", timeout_count);
    end
    @(negedge user_clk);
    n_cmp++;
    if (timeout_count !== 16'd1) begin
      n_bad++; $display("FAIL timeout_count: got %0d required 1", timeout_count);
    end
    @(negedge user_clk);
    n_cmp++;
    if (err_count !== 16'd2) begin
      n_bad++; $display("FAIL timeout_err: got %0d required 2", err_count);
    end
    push_iter(2);
    serve_iter(1);
    push_iter(3);
    serve_iter(0);
    @(negedge user_clk);
    n_cmp++;
    if (pass_count !== 16'd1 || err_count !== 16'd3 || timeout_count !== 16'd1 || test_done !== 1'b1) begin
      n_bad++; $display("FAIL err_totals: got %0d/%0d/%0d done %b required 1/3/1 done 1",
                        pass_count, err_count, timeout_count, test_done);
    end
  endtask

  task automatic test_tag_wrap();
    while (tlp_total < 264) begin
      pulse_restart();
      for (int it = 0; it < 4; it++) begin
        push_iter(it);
        serve_iter(0);
      end
      @(negedge user_clk);
      n_cmp++;
      if (pass_count !== 16'd4 || test_done !== 1'b1) begin
        n_bad++; $display("FAIL wrap_run: pass %0d done %b required 4/1", pass_count, test_done);
      end
    end
    n_cmp++;
    if (tx_tag !== m_tag) begin
      n_bad++; $display("FAIL wrap_tag: got %h required %h", tx_tag, m_tag);
    end
  endtask

  task automatic test_link_drop();
    int highs = 0;
    int starts = 0;
    pulse_restart();
    push_iter(0); serve_iter(0);
    push_iter(1); serve_iter(0);
    push_iter(2);
    serve_tlp(1'b1);
    serve_tlp(1'b0);
    user_lnk_up = 1'b0;
    @(negedge user_clk);
    n_cmp++;
    if ({pass_count, err_count, timeout_count} !== 48'h0 || test_done !== 1'b0) begin
      n_bad++; $display("FAIL drop_clear: got %0d/%0d/%0d done %b required 0/0/0 done 0",
                        pass_count, err_count, timeout_count, test_done);
    end
    n_cmp++;
    if (tx_tag !== m_tag) begin
      n_bad++; $display("FAIL drop_tag: got %h required %h", tx_tag, m_tag);
    end
    tx_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge user_clk);
      tx_done = 1'b0;
      if (tx_start === 1'b1) starts++;
    end
    n_cmp++;
    if (starts != 0) begin
      n_bad++; $display("FAIL drop_idle: %0d tx_start, required 0", starts);
    end
    user_lnk_up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge user_clk);
      if (start_config === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != 1) begin
      n_bad++; $display("FAIL relink_pulse: high %0d cycles, required 1", highs);
    end
    // failed_config beats finished_config; the failed attempt consumes iteration 0.
    for (int it = 1; it < 4; it++) push_iter(it);
    finished_config = 1'b1;
    failed_config   = 1'b1;
    @(negedge user_clk);
    finished_config = 1'b0;
    failed_config   = 1'b0;
    @(negedge user_clk);
    n_cmp++;
    if (err_count !== 16'd1 || pass_count !== 16'd0) begin
      n_bad++; $display("FAIL cfg_failed: err %0d pass %0d, required 1/0", err_count, pass_count);
    end
    for (int it = 1; it < 4; it++) serve_iter(0);
    @(negedge user_clk);
    n_cmp++;
    if (pass_count !== 16'd3 || err_count !== 16'd1 || test_done !== 1'b1) begin
      n_bad++; $display("FAIL relink_totals: got %0d/%0d done %b required 3/1 done 1", pass_count, err_count, test_done);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_link_up();
    test_basic_run();
    test_errors();
    test_tag_wrap();
    test_link_drop();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL leftover_tlps: %0d expected TLPs not issued, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_test_sequencer.md
PIO_TEST_SEQUENCER -- requirements
Module: pio_test_sequencer

Interface
REQ-001 SHALL have parameter TCQ, default 1, simulation clock-to-out delay only.
REQ-002 SHALL have parameter BAR_BASE [63:0], default 64'h0000_0000_1000_0000, target BAR base byte address.
REQ-003 SHALL have parameter BAR_SIZE_DW, default 1024, BAR aperture in DW, power of two, >= 4.
REQ-004 SHALL have parameter ADDR64, default 0: 0 = MemRd32/MemWr32, 1 = MemRd64/MemWr64.
REQ-005 SHALL have parameter LEN_DW, default 1, payload DW per TLP, legal 1..4.
REQ-006 SHALL have parameter MODE, default 0: 0 = write+read, 1 = write-only, 2 = read-only.
REQ-007 SHALL have parameter NUM_ITER, default 4096, iterations per run, 1..65535.
REQ-008 SHALL have parameter CPL_TIMEOUT, default 1024, completion-wait cycles before timeout, >= 2.
REQ-009 SHALL have parameter RD_EXPECT [31:0], default 32'h1234_5678, expected first DW in MODE 2.
REQ-010 SHALL have ports: user_clk in 1 clock; reset in 1 synchronous active-high; user_lnk_up in 1 link status.
REQ-011 SHALL have ports: start_config out 1; finished_config in 1; failed_config in 1; configurator handshake.
REQ-012 SHALL have ports: tx_type out 3; tx_tag out 8; tx_addr out 64; tx_data out 128; tx_length out 11; tx_start out 1; tx_done in 1.
REQ-013 SHALL have ports: rx_type out 1; rx_tag out 8; rx_data out 32; rx_success in 1; rx_fail in 1.
REQ-014 SHALL have ports: restart in 1 (rerun request); test_done out 1; pass_count out 16; err_count out 16; timeout_count out 16.

Function
REQ-015 SHALL register user_lnk_up twice and pulse start_config for exactly 1 cycle on its rising edge.
REQ-016 SHALL implement states WAIT_CFG, WRITE, WRITE_WAIT, READ, READ_WAIT, CPL_WAIT, DONE, ERROR, TESTDONE.
REQ-017 In WAIT_CFG: failed_config -> ERROR (wins over finished_config); finished_config -> WRITE (MODE 0/1) or READ (MODE 2).
REQ-018 WRITE and READ SHALL last 1 cycle and go to WRITE_WAIT/READ_WAIT; tx_start SHALL be high exactly the following cycle.
REQ-019 WRITE_WAIT on tx_done -> READ (MODE 0) or DONE (MODE 1); READ_WAIT on tx_done -> CPL_WAIT.
REQ-020 CPL_WAIT: rx_fail -> ERROR; else rx_success -> DONE; rx_fail wins when both high in one cycle.
REQ-021 CPL_WAIT SHALL count cycles from entry; at CPL_TIMEOUT cycles with neither input -> ERROR and timeout_count +1.
REQ-022 DONE SHALL add 1 to pass_count; ERROR SHALL add 1 to err_count; all status counters saturate at 16'hFFFF.
REQ-023 DONE/ERROR SHALL increment iteration counter; when it reaches NUM_ITER -> TESTDONE, else -> WRITE/READ per MODE.
REQ-024 TESTDONE SHALL hold test_done=1; restart -> clear counters, offset, test_done -> WRITE/READ per MODE next cycle.
REQ-025 restart outside TESTDONE SHALL be ignored.
REQ-026 tx_addr SHALL = BAR_BASE + offset*4; offset starts 0, advances by LEN_DW per iteration.
REQ-027 Offset SHALL wrap to 0 when offset+LEN_DW would exceed BAR_SIZE_DW.
REQ-028 tx_type SHALL be 000 MemRd32, 001 MemWr32, 010 MemRd64, 011 MemWr64, selected by ADDR64; tx_length = LEN_DW.
REQ-029 tx_data DW k (bits 32k+31:32k) SHALL = {iter[15:0], 8'hA5, 6'b0, k[1:0]} for k < LEN_DW; unused DWs 0.
REQ-030 rx_type SHALL be 1 (CplD) for reads, 0 for writes; rx_data SHALL = tx_data[31:0] in MODE 0, RD_EXPECT in MODE 2.
REQ-031 tx_tag SHALL increment by 1 per issued TLP, wrapping 8'hFF -> 8'h00; rx_tag SHALL equal tx_tag combinationally.
REQ-032 tx_* and rx_* fields SHALL be registered in the same cycle as the WRITE/READ state and held until next issue.

Reset
REQ-033 reset SHALL set state WAIT_CFG, all outputs 0, tx_tag 0, offset 0, iteration and status counters 0.
REQ-034 user_lnk_up low SHALL force WAIT_CFG and clear iteration, offset and status counters, mid-transaction included; tx_tag keeps value.

Verification
REQ-035 MODE 0, LEN_DW 1, NUM_ITER 4: link up, finished_config, tx_done/rx_success 3 cycles later -> 8 TLPs, addrs 0x1000_0000..0x1000_000C, pass_count 4, test_done 1.
REQ-036 CPL_WAIT with no rx_* for CPL_TIMEOUT=16 -> ERROR exactly 16 cycles after entry, timeout_count 1, err_count 1.
REQ-037 rx_fail and rx_success high same cycle -> err_count +1, pass_count unchanged.
REQ-038 BAR_SIZE_DW 8, LEN_DW 3, NUM_ITER 4 -> offsets 0,3,0,3; tx_length 3; tx_data[95:64] = {iter,8'hA5,8'h02}.
REQ-039 tx_tag from 8'hFE across 3 TLPs -> tags FF, 00, 01; rx_tag tracks.
REQ-040 user_lnk_up drop in READ_WAIT -> WAIT_CFG next cycle, counters 0; link up -> single start_config pulse.
